// File: rtl/shift_arbiter_seq_pkg.sv
// Shared types and constants for the sequential shift unit.
package shift_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned SHW  = 5;

    typedef enum logic [1:0] {
        SLL  = 2'b00,
        SRL  = 2'b01,
        SRA  = 2'b10,
        RSVD = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        RESP  = 2'b10
    } seq_state_e;

endpackage

// File: rtl/shift_arbiter_seq_if.sv
// Request/response bundle between two requesters, the shift unit and its consumer.
interface shift_arbiter_seq_if #(
    parameter int unsigned XLEN = shift_pkg::XLEN,
    parameter int unsigned SHW  = shift_pkg::SHW
);

    logic [1:0]                i_req_valid;
    logic [1:0]                o_req_ready;
    logic [1:0][1:0]           i_req_op;
    logic [1:0][XLEN-1:0]      i_req_operand;
    logic [1:0][SHW-1:0]       i_req_shamt;
    logic                      o_rsp_valid;
    logic                      i_rsp_ready;
    logic                      o_rsp_id;
    logic [XLEN-1:0]           o_rsp_data;

    // Shift unit side.
    modport slave (
        input  i_req_valid, i_req_op, i_req_operand, i_req_shamt, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data
    );

    // Requester/consumer side.
    modport master (
        output i_req_valid, i_req_op, i_req_operand, i_req_shamt, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data
    );

endinterface

// File: rtl/shift_arbiter_seq_step.sv
// One barrel stage: shifts by 2^k when enabled, otherwise passes data through.
module shift_step #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = 5,
    parameter int unsigned KW   = 3
) (
    input  logic [XLEN-1:0]     i_data,
    input  shift_pkg::shift_op_e i_op,
    input  logic [KW-1:0]       i_k,
    input  logic                i_en,
    output logic [XLEN-1:0]     o_data
);

    logic [SHW-1:0] w_amt;

    // Stage shift: the working MSB is the original sign, so SRA stays exact across stages.
    always_comb begin
        w_amt  = SHW'(1) << i_k;
        o_data = i_data;
        if (i_en) begin
            unique case (i_op)
                shift_pkg::SLL: o_data = i_data << w_amt;
                shift_pkg::SRL: o_data = i_data >> w_amt;
                shift_pkg::SRA: o_data = $signed(i_data) >>> w_amt;
                default:        o_data = i_data;
            endcase
        end
    end

endmodule

// File: rtl/shift_arbiter_seq.sv
// Two-requester round-robin arbiter feeding a single iterative barrel stage.
module shift_arbiter_seq #(
    parameter int unsigned XLEN = shift_pkg::XLEN,
    parameter int unsigned SHW  = shift_pkg::SHW
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    shift_arbiter_seq_if.slave bus
);

    import shift_pkg::*;

    localparam int unsigned KW     = (SHW > 1) ? $clog2(SHW) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(SHW - 1);

    seq_state_e      r_state;
    logic [KW-1:0]   r_k;
    shift_op_e       r_op;
    logic [XLEN-1:0] r_data;
    logic [SHW-1:0]  r_shamt;
    logic            r_id;
    logic            r_last_served;
    logic            r_rsp_valid;

    logic            w_grant_id;
    logic [1:0]      w_ready;
    logic            w_accept;
    logic            w_step_en;
    logic            w_done;
    logic [XLEN-1:0] w_step_out;
    shift_op_e       w_req_op;

    // Grant from current valids only; a tie goes to whoever was not served last.
    always_comb begin
        w_grant_id = 1'b0;
        if (bus.i_req_valid == 2'b10) begin
            w_grant_id = 1'b1;
        end else if (bus.i_req_valid == 2'b11) begin
            w_grant_id = ~r_last_served;
        end
        w_ready = 2'b00;
        if (i_rst_n && (r_state == IDLE) && (|bus.i_req_valid)) begin
            w_ready[w_grant_id] = 1'b1;
        end
    end

    assign bus.o_req_ready = w_ready;
    // Ready is only ever raised towards a valid requester, so ready implies a handshake.
    assign w_accept        = |w_ready;
    assign w_req_op        = shift_op_e'(bus.i_req_op[w_grant_id]);

    // Stage control: finish on the last stage or once no higher shamt bits remain.
    always_comb begin
        w_step_en = r_shamt[r_k];
        w_done    = (r_k == LAST_K) || (((r_shamt >> r_k) >> 1) == '0);
    end

    shift_step #(
        .XLEN (XLEN),
        .SHW  (SHW),
        .KW   (KW)
    ) u_step (
        .i_data (r_data),
        .i_op   (r_op),
        .i_k    (r_k),
        .i_en   (w_step_en),
        .o_data (w_step_out)
    );

    // Sequencer: accept, iterate the stage, hold the result until consumed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_k           <= '0;
            r_op          <= SLL;
            r_data        <= '0;
            r_shamt       <= '0;
            r_id          <= 1'b0;
            r_last_served <= 1'b1;
            r_rsp_valid   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_req_op;
                        r_data  <= bus.i_req_operand[w_grant_id];
                        // Reserved op: zero shamt gives a single pass-through stage.
                        r_shamt <= (w_req_op == RSVD) ? '0 : bus.i_req_shamt[w_grant_id];
                        r_id    <= w_grant_id;
                        r_k     <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_data <= w_step_out;
                    if (w_done) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                RESP: begin
                    if (bus.i_rsp_ready) begin
                        r_last_served <= r_id;
                        r_rsp_valid   <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_rsp_valid = r_rsp_valid;
    assign bus.o_rsp_data  = r_data;
    assign bus.o_rsp_id    = r_id;

endmodule

// File: tb/tb_shift_arbiter_seq.sv
// Directed and randomized checks of shift_arbiter_seq against a behavioural model.
module tb_shift_arbiter_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic model_last;

    shift_arbiter_seq_if bus ();

    shift_arbiter_seq dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input int op, input logic [31:0] a, input int sh);
        case (op)
            0:       return a << sh;
            1:       return a >> sh;
            2:       return 32'($signed(a) >>> sh);
            default: return a;
        endcase
    endfunction

    function automatic int ref_lat(input int op, input int sh);
        int s;
        s = 1;
        if (op == 3) return 1;
        for (int b = 0; b < 5; b++) if (((sh >> b) & 1) == 1) s = b + 1;
        return s;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for o_rsp_valid after an acceptance edge; returns cycles taken.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!bus.o_rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input int id, input int op, input logic [31:0] a, input int sh,
                         input int hold, input string tag);
        logic [31:0] exp_d;
        logic [1:0]  exp_rdy;
        int          lat;
        exp_d = ref_shift(op, a, sh);
        @(negedge clk);
        bus.i_req_valid            = 2'b00;
        bus.i_req_valid[id]        = 1'b1;
        bus.i_req_op[id]           = 2'(op);
        bus.i_req_operand[id]      = a;
        bus.i_req_shamt[id]        = 5'(sh);
        #1;
        exp_rdy = 2'b00;
        exp_rdy[id] = 1'b1;
        check({tag, "/ready"}, 64'(bus.o_req_ready), 64'(exp_rdy));
        @(posedge clk); #1;
        bus.i_req_valid = 2'b00;
        wait_rsp(lat);
        check({tag, "/lat"}, 64'(lat), 64'(ref_lat(op, sh)));
        check({tag, "/data"}, 64'(bus.o_rsp_data), 64'(exp_d));
        check({tag, "/id"}, 64'(bus.o_rsp_id), 64'(id));
        if (hold > 0) bus.i_req_valid = 2'b11;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "/hold_valid"}, 64'(bus.o_rsp_valid), 64'(1));
            check({tag, "/hold_data"}, 64'(bus.o_rsp_data), 64'(exp_d));
            check({tag, "/hold_id"}, 64'(bus.o_rsp_id), 64'(id));
            check({tag, "/hold_ready"}, 64'(bus.o_req_ready), 64'(0));
        end
        bus.i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_rsp_ready = 1'b0;
        check({tag, "/rsp_drop"}, 64'(bus.o_rsp_valid), 64'(0));
        model_last = id[0];
        if (hold > 0) begin
            exp_rdy = model_last ? 2'b01 : 2'b10;
            check({tag, "/resume"}, 64'(bus.o_req_ready), 64'(exp_rdy));
            bus.i_req_valid = 2'b00;
        end
    endtask

    // Both requesters held valid: grants must alternate starting from !last_served.
    task automatic tie_rounds(input int n);
        int          ops [2];
        logic [31:0] as  [2];
        int          shs [2];
        int          g;
        int          lat;
        logic [1:0]  exp_rdy;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                ops[r] = int'($urandom_range(0, 3));
                as[r]  = $urandom;
                shs[r] = int'($urandom_range(0, 31));
                bus.i_req_op[r]      = 2'(ops[r]);
                bus.i_req_operand[r] = as[r];
                bus.i_req_shamt[r]   = 5'(shs[r]);
            end
            bus.i_req_valid = 2'b11;
            g = model_last ? 0 : 1;
            #1;
            exp_rdy = (g == 0) ? 2'b01 : 2'b10;
            check("tie/ready", 64'(bus.o_req_ready), 64'(exp_rdy));
            @(posedge clk); #1;
            check("tie/ready_pulse", 64'(bus.o_req_ready), 64'(0));
            wait_rsp(lat);
            check("tie/lat", 64'(lat), 64'(ref_lat(ops[g], shs[g])));
            check("tie/id", 64'(bus.o_rsp_id), 64'(g));
            check("tie/data", 64'(bus.o_rsp_data), 64'(ref_shift(ops[g], as[g], shs[g])));
            bus.i_rsp_ready = 1'b1;
            @(posedge clk); #1;
            bus.i_rsp_ready = 1'b0;
            model_last = g[0];
            exp_rdy = (g == 0) ? 2'b10 : 2'b01;
            check("tie/next_ready", 64'(bus.o_req_ready), 64'(exp_rdy));
        end
        bus.i_req_valid = 2'b00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_req_valid   = 2'b11;
        bus.i_req_op      = '0;
        bus.i_req_operand = '0;
        bus.i_req_shamt   = '0;
        bus.i_rsp_ready   = 1'b0;
        model_last        = 1'b1;

        // Reset state, valids high while reset is asserted.
        #12;
        check("rst/ready", 64'(bus.o_req_ready), 64'(0));
        check("rst/valid", 64'(bus.o_rsp_valid), 64'(0));
        check("rst/data", 64'(bus.o_rsp_data), 64'(0));
        check("rst/id", 64'(bus.o_rsp_id), 64'(0));
        bus.i_req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // Grant order 0,1,0,1 from reset.
        tie_rounds(4);

        // Directed cases.
        do_op(0, 0, 32'h0F0F_0F0F, 4, 0, "sll4");
        do_op(1, 2, 32'hF0F0_F0F0, 31, 0, "sra31");
        do_op(1, 1, 32'hF0F0_F0F0, 31, 0, "srl31");
        do_op(0, 1, 32'hF0F0_F0F0, 0, 0, "srl0");
        do_op(1, 3, 32'hDEAD_BEEF, 17, 0, "rsvd");

        // Response stall for 3 cycles with both requesters waiting.
        do_op(0, 2, 32'h8000_1234, 9, 3, "stall");

        // Reset pulse during SHIFT discards the operation.
        @(negedge clk);
        bus.i_req_valid      = 2'b01;
        bus.i_req_op[0]      = 2'd2;
        bus.i_req_operand[0] = 32'hF0F0_F0F0;
        bus.i_req_shamt[0]   = 5'd31;
        @(posedge clk); #1;
        bus.i_req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst/ready", 64'(bus.o_req_ready), 64'(0));
        check("mid_rst/valid", 64'(bus.o_rsp_valid), 64'(0));
        check("mid_rst/data", 64'(bus.o_rsp_data), 64'(0));
        check("mid_rst/id", 64'(bus.o_rsp_id), 64'(0));
        @(negedge clk);
        bus.i_req_valid = 2'b00;
        rst_n      = 1'b1;
        model_last = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check("mid_rst/no_rsp", 64'(bus.o_rsp_valid), 64'(0));
        end
        do_op(1, 0, 32'h0000_00A5, 7, 0, "post_rst");

        // Sweep every shift amount for the three real ops on two patterns.
        for (int op = 0; op < 3; op++) begin
            for (int p = 0; p < 2; p++) begin
                for (int sh = 0; sh < 32; sh++) begin
                    do_op(sh % 2, op, (p == 0) ? 32'h0F0F_0F0F : 32'hF0F0_F0F0, sh, 0,
                          $sformatf("sweep_op%0d_p%0d_sh%0d", op, p, sh));
                end
            end
        end

        // Random traffic, including reserved ops and response stalls.
        for (int i = 0; i < 40; i++) begin
            do_op(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom,
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 2)),
                  $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_arbiter_seq.md
# shift_arbiter_seq

Shared, multi-cycle shift unit for the core datapath. It arbitrates between two requesters with round-robin priority, then runs one SLL/SRL/SRA operation through a single barrel stage per cycle, five stages at most, ending early once no shift-amount bits remain. The block replaces duplicated combinational shifters where area matters. Its results are bit-identical to `sll`, `srl` and `sra`.

## Interface
- `XLEN`, default 32: operand and result width.
- `SHW`, default 5: shift-amount width, equal to log2(`XLEN`).
- `i_clk` in 1: the single clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_req_valid` in 2: per-requester request valid. Bit k belongs to requester k.
- `o_req_ready` in 2 out: per-requester accept. This output is combinational.
- `i_req_op` in 2x2: per-requester opcode. 00 = SLL, 01 = SRL, 10 = SRA, 11 = reserved.
- `i_req_operand` in 2x`XLEN`: per-requester operand_a.
- `i_req_shamt` in 2x`SHW`: per-requester shift amount (operand_b).
- `o_rsp_valid` out 1: result valid. Registered.
- `i_rsp_ready` in 1: consumer accepts the result.
- `o_rsp_id` out 1: index of the requester that owns the result.
- `o_rsp_data` out `XLEN`: shift result.

## Operation
FSM states: IDLE, SHIFT, RESP.

**IDLE**
- Grant logic:
  - If only one valid is high, grant that requester.
  - If both are high, grant the requester that is not `last_served`.
- `o_req_ready` is high only for the granted requester, and only in IDLE. Every other ready is 0.
- On a valid&ready handshake:
  - Latch op, operand, shamt and id.
  - Clear the stage counter k to 0.
  - Go to SHIFT.

**SHIFT** (one stage per cycle, stage k)
- If shamt[k] = 1, shift the working value by 2^k:
  - SLL fills with zeros from the right.
  - SRL fills with zeros from the left.
  - SRA fills with the working value's MSB. This preserves the sign of the original operand.
- Go to RESP after the stage where k = `SHW`-1, or earlier once shamt[`SHW`-1:k+1] == 0. Otherwise k increments.
- Number of SHIFT cycles S = max(1, index of the highest set shamt bit + 1). shamt = 0 gives S = 1.
- Reserved op: S = 1, and the result equals the operand unmodified.

**RESP**
- `o_rsp_valid` = 1. `o_rsp_data` and `o_rsp_id` stay stable until `i_rsp_ready`.
- On the handshake:
  - `last_served` := `o_rsp_id`.
  - Go to IDLE.
- No new request is accepted while in SHIFT or RESP.

**Reset**, asserted at any time, including mid-operation:
- State goes to IDLE, and any in-flight operation is discarded with no response.
- `o_rsp_valid` = 0, `o_rsp_data` = 0, `o_rsp_id` = 0, `last_served` = 1 (so requester 0 wins the first tie).
- `o_req_ready` = 0 while `i_rst_n` is low.

## Timing
- Accept at edge E0. The stages are applied at edges E1 through ES. `o_rsp_valid` is high from the cycle after ES, i.e. S cycles after acceptance.
- Minimum request-to-response latency is 1 cycle (shamt = 0). Maximum is 5 (shamt[4] = 1).
- Response handshake at edge ER: state is IDLE after ER. The earliest next acceptance is edge ER+1.
- A requester may drop valid before it is granted. Arbitration uses current-cycle valids only and keeps no state apart from `last_served`.
- Any result bits shifted beyond `XLEN` are discarded. Shift amounts never exceed `XLEN`-1.

## Structure
- Package `shift_pkg` holds:
  - `shift_op_e` with values SLL/SRL/SRA/RSVD;
  - `seq_state_e` with values IDLE/SHIFT/RESP;
  - the `XLEN` and `SHW` constants.
- Sub-module `shift_step`: a combinational single stage. Inputs are data, op, stage index k and enable (shamt[k]); output is the data shifted by 2^k or passed through. It is instantiated once, and the FSM and registers sit around it.

## Test plan
- Req0 SLL 0x0F0F0F0F by 4 -> `o_rsp_data` = 0xF0F0F0F0, `o_rsp_id` = 0, valid 3 cycles after accept.
- Req1 SRA 0xF0F0F0F0 by 31 -> 0xFFFFFFFF after 5 cycles. SRL with the same inputs -> 0x00000001.
- SRL 0xF0F0F0F0 by 0 -> 0xF0F0F0F0 after 1 cycle. Reserved op -> the operand unchanged after 1 cycle.
- Both valids held high after reset -> grant order 0, 1, 0, 1. Each ready pulses for exactly one cycle, and only in IDLE.
- `i_rsp_ready` held low for 3 cycles in RESP -> data and id stable, both `o_req_ready` at 0, acceptance resumes on the cycle after the handshake.
- `i_rst_n` pulsed low during SHIFT -> no `o_rsp_valid`, outputs 0. The next request is served normally with correct data.
- Sweep shamt 0..31 on 0x0F0F0F0F and on 0xF0F0F0F0 for all three ops, comparing against `<<`, `>>` and signed `>>>`.
